verify_input_loader: RTL and testbench

//  Upstream feeder for the verify top. Accepts a 32-bit signature word stream (valid/ready),

---
 rtl/verify_input_loader_pkg.sv | 29 ++
 rtl/verify_input_loader_if.sv | 12 +
 rtl/verify_input_loader_watchdog.sv | 32 +++
 rtl/verify_input_loader.sv | 148 ++++++++++++++
 tb/tb_verify_input_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/verify_input_loader_pkg.sv
// Shared definitions for the verify input loader: FSM states and the
// word-count / address-width derivations from the security level.
package verify_input_loader_pkg;

  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_SEED = 3'd1,
    S_LD_H2   = 3'd2,
    S_KICK    = 3'd3,
    S_WAIT    = 3'd4,
    S_FIN     = 3'd5
  } state_e;

  // Never returns 0 so that a count of 1 still yields a legal 1-bit vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int seed_words(input int lambda);
    return lambda / WORD_BITS;
  endfunction

  function automatic int h2_words(input int lambda);
    return (2 * lambda) / WORD_BITS;
  endfunction

endpackage

// File: rtl/verify_input_loader_if.sv
// Signature word stream (valid/ready) between the input FIFO and the loader.
interface verify_input_loader_if;
  import verify_input_loader_pkg::*;

  logic [WORD_BITS-1:0] sig_data;
  logic                 sig_valid;
  logic                 sig_ready;

  modport master (output sig_data, output sig_valid, input sig_ready);
  modport slave  (input sig_data, input sig_valid, output sig_ready);

endinterface

// File: rtl/verify_input_loader_watchdog.sv
// Clearable cycle counter that flags when a verify run has taken
// TIMEOUT_CYCLES cycles; a TIMEOUT_CYCLES of 0 never expires.
module verify_input_loader_watchdog
  import verify_input_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int            CW   = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LAST);

endmodule

// File: rtl/verify_input_loader.sv
// Feeds one signature into verify: seed_h words, then h2 words, then a start
// pulse, and waits for verify done under a watchdog.
module verify_input_loader
  import verify_input_loader_pkg::*;
#(
  parameter int LAMBDA         = 128,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_start,
  verify_input_loader_if.slave                   sig_if,
  output logic                                   o_seed_h_wr_en,
  output logic [clog2_min1(LAMBDA)-1:0]          o_seed_h_addr,
  output logic [WORD_BITS-1:0]                   o_seed_h,
  output logic                                   o_h2_wr_en,
  output logic [clog2_min1(h2_words(LAMBDA))-1:0] o_h2_addr,
  output logic [WORD_BITS-1:0]                   o_h2,
  output logic                                   o_verify_start,
  input  logic                                   i_verify_done,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_err
);

  localparam int SEED_WORDS = seed_words(LAMBDA);
  localparam int H2_WORDS   = h2_words(LAMBDA);
  localparam int SAW        = clog2_min1(LAMBDA);
  localparam int WCW        = clog2_min1(H2_WORDS);

  state_e               r_state;
  state_e               w_next_state;
  logic [WCW-1:0]       r_word_cnt;
  logic                 r_seed_h_wr_en;
  logic [SAW-1:0]       r_seed_h_addr;
  logic [WORD_BITS-1:0] r_seed_h;
  logic                 r_h2_wr_en;
  logic [WCW-1:0]       r_h2_addr;
  logic [WORD_BITS-1:0] r_h2;
  logic                 r_verify_start;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_last_seed;
  logic                 w_last_h2;
  logic                 w_wd_clear;
  logic                 w_wd_enable;
  logic                 w_wd_expire;
  logic                 w_err_set;

  assign sig_if.sig_ready = (r_state == S_LD_SEED) || (r_state == S_LD_H2);
  assign w_accept         = sig_if.sig_valid && sig_if.sig_ready;
  assign w_last_seed      = (r_word_cnt == WCW'(SEED_WORDS - 1));
  assign w_last_h2        = (r_word_cnt == WCW'(H2_WORDS - 1));

  verify_input_loader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A done arriving on the expiry cycle is checked first, so it wins over o_err.
  always_comb begin
    w_next_state = r_state;
    w_wd_clear   = 1'b0;
    w_wd_enable  = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE:    if (i_start) w_next_state = S_LD_SEED;
      S_LD_SEED: if (w_accept && w_last_seed) w_next_state = S_LD_H2;
      S_LD_H2:   if (w_accept && w_last_h2) w_next_state = S_KICK;
      S_KICK: begin
        w_next_state = S_WAIT;
        w_wd_clear   = 1'b1;
      end
      S_WAIT: begin
        if (i_verify_done) begin
          w_next_state = S_FIN;
        end else if (w_wd_expire) begin
          w_next_state = S_IDLE;
          w_err_set    = 1'b1;
        end else begin
          w_wd_enable = 1'b1;
        end
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Write port address/data hold their last value between strobes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_word_cnt     <= '0;
      r_seed_h_wr_en <= 1'b0;
      r_seed_h_addr  <= '0;
      r_seed_h       <= '0;
      r_h2_wr_en     <= 1'b0;
      r_h2_addr      <= '0;
      r_h2           <= '0;
      r_verify_start <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_seed_h_wr_en <= 1'b0;
      r_h2_wr_en     <= 1'b0;
      r_verify_start <= (r_state == S_KICK);
      r_err          <= w_err_set;
      if (r_state == S_IDLE) begin
        r_word_cnt <= '0;
      end
      if (w_accept && (r_state == S_LD_SEED)) begin
        r_seed_h_wr_en <= 1'b1;
        r_seed_h_addr  <= SAW'(r_word_cnt);
        r_seed_h       <= sig_if.sig_data;
        r_word_cnt     <= w_last_seed ? '0 : r_word_cnt + 1'b1;
      end
      if (w_accept && (r_state == S_LD_H2)) begin
        r_h2_wr_en <= 1'b1;
        r_h2_addr  <= r_word_cnt;
        r_h2       <= sig_if.sig_data;
        r_word_cnt <= w_last_h2 ? '0 : r_word_cnt + 1'b1;
      end
    end
  end

  assign o_seed_h_wr_en = r_seed_h_wr_en;
  assign o_seed_h_addr  = r_seed_h_addr;
  assign o_seed_h       = r_seed_h;
  assign o_h2_wr_en     = r_h2_wr_en;
  assign o_h2_addr      = r_h2_addr;
  assign o_h2           = r_h2;
  assign o_verify_start = r_verify_start;
  assign o_err          = r_err;
  assign o_done         = (r_state == S_FIN);
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_verify_input_loader.sv
// Directed bench for verify_input_loader (LAMBDA=128, TIMEOUT_CYCLES=16);
// inputs change and outputs are sampled on the falling clock edge.
module tb_verify_input_loader;

  localparam int LAMBDA  = 128;
  localparam int TIMEOUT = 16;

  logic        clk        = 1'b0;
  logic        rstN       = 1'b1;
  logic        start      = 1'b0;
  logic        verifyDone = 1'b0;
  logic        seedWrEn;
  logic [6:0]  seedAddr;
  logic [31:0] seedData;
  logic        h2WrEn;
  logic [2:0]  h2Addr;
  logic [31:0] h2Data;
  logic        verifyStart;
  logic        busy;
  logic        done;
  logic        err;

  int nChecks     = 0;
  int nFails      = 0;
  int seedStrobes = 0;
  int h2Strobes   = 0;

  verify_input_loader_if sigIf ();

  always #5 clk = ~clk;

  verify_input_loader #(
    .LAMBDA        (LAMBDA),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rstN),
    .i_start        (start),
    .sig_if         (sigIf),
    .o_seed_h_wr_en (seedWrEn),
    .o_seed_h_addr  (seedAddr),
    .o_seed_h       (seedData),
    .o_h2_wr_en     (h2WrEn),
    .o_h2_addr      (h2Addr),
    .o_h2           (h2Data),
    .o_verify_start (verifyStart),
    .i_verify_done  (verifyDone),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err)
  );

  // Running totals of write strobes, used to catch extra or missing writes.
  always @(negedge clk) begin
    if (seedWrEn) seedStrobes <= seedStrobes + 1;
    if (h2WrEn)   h2Strobes   <= h2Strobes + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL globalTimeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] d,
                               input logic v, input logic dn);
    start           = s;
    sigIf.sig_data  = d;
    sigIf.sig_valid = v;
    verifyDone      = dn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Starts from an IDLE falling edge and ends on the cycle showing o_verify_start.
  task automatic loadSignature(input bit gaps, input logic [31:0] base);
    int seedS0;
    int h2S0;
    seedS0 = seedStrobes;
    h2S0   = h2Strobes;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("loadBusy", 32'(busy), 32'd1);
    checkOutput("loadReady", 32'(sigIf.sig_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (gaps) begin
        applyStimulus(1'b0, 32'hDEAD0000 + i, 1'b0, 1'b0);
        nextCycle();
        checkOutput("gapNoStrobe", {30'b0, seedWrEn, h2WrEn}, 32'b00);
      end
      applyStimulus(1'b0, base + i, 1'b1, 1'b0);
      nextCycle();
      if (i < 4) begin
        checkOutput("seedStrobe", {30'b0, seedWrEn, h2WrEn}, 32'b10);
        checkOutput("seedAddr", 32'(seedAddr), i);
        checkOutput("seedData", seedData, base + i);
      end else begin
        checkOutput("h2Strobe", {30'b0, seedWrEn, h2WrEn}, 32'b01);
        checkOutput("h2Addr", 32'(h2Addr), i - 4);
        checkOutput("h2Data", h2Data, base + i);
      end
    end
    checkOutput("kickReady", 32'(sigIf.sig_ready), 32'd0);
    checkOutput("kickNoStartYet", 32'(verifyStart), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("verifyStart", {30'b0, verifyStart, h2WrEn}, 32'b10);
    checkOutput("seedCount", seedStrobes - seedS0, 32'd4);
    checkOutput("h2Count", h2Strobes - h2S0, 32'd8);
  endtask

  // Raises verify done five cycles after the start pulse.
  task automatic finishRun();
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      checkOutput("waitQuiet", {29'b0, verifyStart, done, err}, 32'b000);
      checkOutput("waitBusy", 32'(busy), 32'd1);
    end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("donePulse", {29'b0, busy, done, err}, 32'b110);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("doneIdle", {29'b0, busy, done, err}, 32'b000);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {25'b0, sigIf.sig_ready, seedWrEn, h2WrEn, verifyStart,
                      busy, done, err}, 32'd0);
    checkOutput({tag, "Data"}, seedData | h2Data | {25'b0, seedAddr} | {29'b0, h2Addr},
                32'd0);
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rstN = 1'b0;
    #2 checkAllZero("resetState");
    nextCycle();
    nextCycle();
    rstN = 1'b1;
    nextCycle();

    $display("[TB] back-to-back load");
    loadSignature(1'b0, 32'h0);
    finishRun();

    $display("[TB] load with valid gaps");
    loadSignature(1'b1, 32'h0);
    finishRun();

    $display("[TB] words and done while idle");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'hA5A50000 + k, 1'b1, 1'b1);
      nextCycle();
      checkOutput("idleIgnore", {28'b0, sigIf.sig_ready, seedWrEn, h2WrEn, busy}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();

    $display("[TB] watchdog expiry");
    loadSignature(1'b0, 32'h200);
    for (int k = 1; k <= 15; k++) begin
      nextCycle();
      checkOutput("toWait", {28'b0, busy, verifyStart, done, err}, 32'b1000);
    end
    nextCycle();
    checkOutput("toErrPulse", {29'b0, busy, done, err}, 32'b001);
    nextCycle();
    checkOutput("toErrEnd", {29'b0, busy, done, err}, 32'b000);

    $display("[TB] done on expiry cycle");
    loadSignature(1'b0, 32'h280);
    for (int k = 1; k <= 14; k++) nextCycle();
    checkOutput("coincideWait", {29'b0, busy, done, err}, 32'b100);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("coincideDone", {29'b0, busy, done, err}, 32'b110);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("coincideEnd", {29'b0, busy, done, err}, 32'b000);

    $display("[TB] reset during h2 load");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    nextCycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'h100 + i, 1'b1, 1'b0);
      nextCycle();
    end
    checkOutput("preResetH2", {30'b0, h2WrEn, busy}, 32'b11);
    #2 rstN = 1'b0;
    #1 checkAllZero("midRunReset");
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    rstN = 1'b1;
    nextCycle();
    checkOutput("postResetIdle", {29'b0, busy, done, err}, 32'b000);
    loadSignature(1'b0, 32'h300);
    finishRun();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
